// File: rtl/axis_digest_tx.sv
// axis_digest_tx
// Streams a SHA-3 digest out of a captured Keccak state over an AXI4-Stream
// style master port. A single-cycle LOAD captures the low 512 flat bits of the
// state plus the digest length, and the block then emits ceil(L/DATA_WIDTH)
// words, least-significant word first. Bits at or above the digest length are
// forced to zero.
//
// Ports:
//   ACLK      - clock, rising edge
//   ARESETn   - synchronous active-low reset
//   D_in      - Keccak state; lane [x][y] occupies flat bits 64*(5y+x) +: 64
//   LOAD      - capture request (accepted in IDLE or on the final handshake)
//   MODE      - digest length sampled with LOAD: 0=224 1=256 2=384 3=512
//   M_TDATA   - stream data word (zero while M_TVALID is low)
//   M_TVALID  - word valid
//   M_TREADY  - downstream ready
//   M_TLAST   - final word of the digest
//   M_TUSER   - MODE captured for the current packet
//   BUSY      - high while a packet is outstanding
module axis_digest_tx #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [0:4][0:4][63:0] D_in,
  input  logic                  LOAD,
  input  logic [1:0]            MODE,
  output logic [DATA_WIDTH-1:0] M_TDATA,
  output logic                  M_TVALID,
  input  logic                  M_TREADY,
  output logic                  M_TLAST,
  output logic [1:0]            M_TUSER,
  output logic                  BUSY
);

  // Index of the final word for each digest length: ceil(L/DATA_WIDTH) - 1.
  localparam logic [5:0] LAST_224 = 6'((224 + DATA_WIDTH - 1) / DATA_WIDTH - 1);
  localparam logic [5:0] LAST_256 = 6'((256 + DATA_WIDTH - 1) / DATA_WIDTH - 1);
  localparam logic [5:0] LAST_384 = 6'((384 + DATA_WIDTH - 1) / DATA_WIDTH - 1);
  localparam logic [5:0] LAST_512 = 6'((512 + DATA_WIDTH - 1) / DATA_WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [5:0]     cnt;
  logic [5:0]     cnt_nxt;
  logic [511:0]   shadow;
  logic [1:0]     mode_q;
  logic           capture;
  logic           hs;
  logic           last_word;
  logic [5:0]     last_idx;
  logic [511:0]   len_mask;
  logic [511:0]   masked;
  logic [511:0]   shifted;
  logic [1599:0]  flat;
  logic           unused_lanes;

  // Keccak lane order: lane [x][y] lands at flat offset 64*(5y+x).
  for (genvar y = 0; y < 5; y++) begin : g_row
    for (genvar x = 0; x < 5; x++) begin : g_col
      assign flat[64*(5*y+x) +: 64] = D_in[x][y];
    end
  end

  // Only the first eight lanes can ever hold digest bits.
  assign unused_lanes = ^flat[1599:512];

  // Per-mode word count and valid-bit mask.
  always_comb begin
    last_idx = LAST_224;
    len_mask = '0;
    unique case (mode_q)
      2'd0: begin
        last_idx = LAST_224;
        len_mask = {{288{1'b0}}, {224{1'b1}}};
      end
      2'd1: begin
        last_idx = LAST_256;
        len_mask = {{256{1'b0}}, {256{1'b1}}};
      end
      2'd2: begin
        last_idx = LAST_384;
        len_mask = {{128{1'b0}}, {384{1'b1}}};
      end
      default: begin
        last_idx = LAST_512;
        len_mask = '1;
      end
    endcase
  end

  assign masked    = shadow & len_mask;
  assign shifted   = masked >> (cnt * DATA_WIDTH);
  assign last_word = (cnt == last_idx);
  assign hs        = M_TVALID && M_TREADY;

  // State register
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a LOAD on the final handshake restarts the packet
  // without passing through IDLE so the stream has no bubble.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (LOAD) begin
          capture   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          if (last_word) begin
            cnt_nxt = '0;
            if (LOAD) begin
              capture = 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            cnt_nxt = cnt + 6'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      cnt    <= '0;
      shadow <= '0;
      mode_q <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (capture) begin
        shadow <= flat[511:0];
        mode_q <= MODE;
      end
    end
  end

  // Outputs
  always_comb begin
    M_TVALID = (state == SEND);
    BUSY     = (state == SEND);
    M_TLAST  = (state == SEND) && last_word;
    M_TUSER  = mode_q;
    M_TDATA  = (state == SEND) ? shifted[DATA_WIDTH-1:0] : '0;
  end

endmodule

// File: doc/axis_digest_tx.md
AXIS_DIGEST_TX -- requirements
Module: axis_digest_tx

Interface
REQ-001 Parameter: DATA_WIDTH, default 16, output word width in bits; legal values are 8, 16, 32 and 64.
REQ-002 ACLK  input  1  system clock; all logic SHALL be on the rising edge.
REQ-003 ARESETn  input  1  synchronous, active-low reset.
REQ-004 D_in  input  [0:4][0:4][63:0]  Keccak state; lane [x][y] occupies flat bits 64*(5y+x)+63 : 64*(5y+x).
REQ-005 LOAD  input  1  single-cycle request to capture D_in and stream the digest.
REQ-006 MODE  input  2  digest length, sampled with LOAD: 0=224, 1=256, 2=384, 3=512 bits.
REQ-007 M_TDATA  output  DATA_WIDTH  stream data word.
REQ-008 M_TVALID  output  1  word valid.
REQ-009 M_TREADY  input  1  downstream ready.
REQ-010 M_TLAST  output  1  marks the final word of the digest.
REQ-011 M_TUSER  output  2  MODE captured for the current packet.
REQ-012 BUSY  output  1  high while a packet is outstanding.

Function
REQ-013 A 2-state FSM SHALL be used: IDLE and SEND.
REQ-014 In IDLE with LOAD=1, the block SHALL capture flat bits 511:0 of D_in into a shadow register, capture MODE, clear the word counter and enter SEND.
REQ-015 The capture SHALL take 1 cycle: M_TVALID SHALL rise on the first edge after the LOAD edge.
REQ-016 Word count N SHALL be ceil(L/DATA_WIDTH), where L is the digest length.
- DW=16: 14/16/24/32 words.
- DW=64: 4/4/6/8 words.
REQ-017 Word i SHALL be shadow bits DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i, with word 0 first.
REQ-018 Bits at flat positions >= L SHALL be driven 0; this covers the partial last word for 224 at DW=64, whose upper 32 bits are zero.
REQ-019 The word counter SHALL advance only on M_TVALID && M_TREADY.
REQ-020 While M_TVALID=1 and M_TREADY=0, M_TDATA, M_TLAST and M_TUSER SHALL hold stable.
REQ-021 M_TVALID SHALL NOT drop until its handshake occurs.
REQ-022 M_TLAST SHALL be 1 exactly while the counter equals N-1 and M_TVALID=1.
REQ-023 M_TUSER SHALL equal the captured MODE throughout SEND.
REQ-024 On the final handshake (M_TLAST && M_TREADY), the FSM SHALL return to IDLE and M_TVALID SHALL go 0 on the next edge, unless REQ-025 applies.
REQ-025 A LOAD coincident with the final handshake SHALL be accepted: capture, stay in SEND, counter=0, and M_TVALID stays 1 with no bubble.
REQ-026 A LOAD in SEND other than on the final handshake SHALL be ignored; the shadow register and MODE SHALL NOT change.
REQ-027 BUSY SHALL equal (state==SEND).
REQ-028 Changes on D_in after capture SHALL NOT affect the words streamed.
REQ-029 The counter SHALL be 6 bits wide, supporting up to 64 words at DW=8, and SHALL NOT wrap within a packet.

Reset
REQ-030 With ARESETn=0 at a rising edge:
- state IDLE, counter 0, shadow register 0;
- M_TVALID=0, M_TLAST=0, M_TDATA=0, M_TUSER=0, BUSY=0.
REQ-031 Reset asserted mid-packet SHALL abort it with no further words.
REQ-032 LOAD SHALL be ignored while ARESETn=0.

Verification
REQ-033 DW=16, MODE=1, D_in lane[0][0]=64'h0123456789ABCDEF, M_TREADY=1 -> 16 words on consecutive cycles:
- first word 16'hCDEF, second word 16'h89AB;
- TLAST only on word 15;
- TUSER=1;
- BUSY falls after word 15.
REQ-034 DW=64, MODE=0, lane[3][0]=64'hFFFF_FFFF_FFFF_FFFF -> 4 words; word 3 = 64'h0000_0000_FFFF_FFFF with TLAST=1.
REQ-035 DW=16, MODE=3, M_TREADY toggling randomly -> 32 words in order, no loss or duplication; TDATA and TLAST stable while stalled.
REQ-036 LOAD on the final-handshake cycle with new MODE=2 -> next cycle TVALID stays 1, word 0 of the new state, TUSER=2, 24 words.
REQ-037 LOAD pulsed at word 5 of a packet -> ignored; the remaining words come from the original capture.
REQ-038 ARESETn=0 for 1 cycle at word 7 -> next cycle TVALID=0, BUSY=0, TDATA=0; a following LOAD restarts at word 0.
